// File: rtl/sim_src_seq_pkg.sv
// -----------------------------------------------------------------------------
// sim_src_seq_pkg
// Shared definitions for the simulation reset-sequence source:
//   - state_e         : sequencer FSM state encoding
//   - DEF_*           : default parameter values for sim_src_seq
//   - calc_last_edge  : edge index L at which the last channel is released
//   - max_of4         : helper for the counter-width elaboration check
// -----------------------------------------------------------------------------
package sim_src_seq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  localparam int DEF_N_CH     = 4;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_START    = 2;
  localparam int DEF_DURATION = 4;
  localparam int DEF_STAGGER  = 1;
  localparam int DEF_TICK_DIV = 4;

  // Edge index (counted from the sequence start edge) of the last release.
  function automatic int calc_last_edge(input int start, input int duration,
                                        input int stagger, input int n_ch);
    return start + duration + (n_ch - 1) * stagger;
  endfunction

  function automatic longint max_of4(input longint a, input longint b,
                                     input longint c, input longint d);
    longint m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sim_src_tick_div.sv
// -----------------------------------------------------------------------------
// sim_src_tick_div
// Periodic single-cycle pulse generator. While enabled, o_pulse is high for one
// cycle after every TICK_DIV-th enabled edge. i_clr restarts the period.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : synchronous active-low reset
//   i_en     : count enable (counter holds, pulse low when 0)
//   i_clr    : synchronous clear of counter and pulse
//   o_pulse  : registered single-cycle pulse
// -----------------------------------------------------------------------------
module sim_src_tick_div #(
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_pulse
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  // Divider counter: reloads to zero on the terminal count, so it never wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (!i_en) begin
      r_cnt   <= r_cnt;
      r_pulse <= 1'b0;
    end else if (r_cnt == CNT_W'(TICK_DIV - 1)) begin
      r_cnt   <= '0;
      r_pulse <= 1'b1;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
      r_pulse <= 1'b0;
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/sim_src_seq.sv
// -----------------------------------------------------------------------------
// sim_src_seq
// Simulation reset-sequence source. After rst_n or restart, waits START cycles,
// asserts all channel resets for DURATION cycles, then releases channel i at
// START+DURATION+i*STAGGER. Once the last channel is released, done stays high
// and (optionally) tick pulses every TICK_DIV cycles.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset (priority over restart)
//   restart : synchronous sequence restart
//   ch_rst  : per-channel active-high reset outputs (registered)
//   done    : high once all channels are released (registered)
//   tick    : periodic one-cycle pulse in RUN (registered)
// Configuration macro:
//   SIM_SRC_SEQ_TICK_EN : when defined, the tick divider is instantiated;
//                         otherwise tick is tied low.
// -----------------------------------------------------------------------------
module sim_src_seq
  import sim_src_seq_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int START    = DEF_START,
  parameter int DURATION = DEF_DURATION,
  parameter int STAGGER  = DEF_STAGGER,
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            restart,
  output logic [N_CH-1:0] ch_rst,
  output logic            done,
  output logic            tick
);

  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam longint CNT_CAP = (longint'(1) << CNT_W) - longint'(1);
  localparam longint CNT_NEED = max_of4(longint'(START), longint'(DURATION),
                                        longint'((N_CH - 1) * STAGGER),
                                        longint'(TICK_DIV));
  // Releasing happens in zero cycles when there is nothing to stagger.
  localparam bit SKIP_RELEASE = (N_CH == 1) || (STAGGER == 0);
  localparam logic [N_CH-1:0] W_ONE = N_CH'(1);

  // Elaboration-time parameter checks.
  if (CNT_NEED > CNT_CAP) begin : g_cnt_w_chk
    $fatal(1, "sim_src_seq: CNT_W=%0d too narrow for value %0d", CNT_W, CNT_NEED);
  end
  if (N_CH < 1 || N_CH > 16) begin : g_nch_chk
    $fatal(1, "sim_src_seq: N_CH=%0d out of range 1..16", N_CH);
  end
  if (START < 1 || DURATION < 1 || STAGGER < 0 || TICK_DIV < 2) begin : g_par_chk
    $fatal(1, "sim_src_seq: illegal timing parameters");
  end

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [N_CH-1:0]   r_ch_rst;
  logic              r_done;

  // Sequencer FSM. r_cnt counts edges inside the current phase and is zeroed
  // on each phase change, so it never exceeds its terminal value.
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      r_state  <= ST_WAIT;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_ch_rst <= '0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (r_cnt == CNT_W'(START - 1)) begin
            r_state  <= ST_HOLD;
            r_cnt    <= '0;
            r_ch_rst <= '1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (r_cnt == CNT_W'(DURATION - 1)) begin
            r_cnt <= '0;
            if (SKIP_RELEASE) begin
              r_ch_rst <= '0;
              r_done   <= 1'b1;
              r_state  <= ST_RUN;
            end else begin
              r_ch_rst <= r_ch_rst & ~W_ONE;
              r_idx    <= IDX_W'(1);
              r_state  <= ST_RELEASE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (r_cnt == CNT_W'(STAGGER - 1)) begin
            r_cnt    <= '0;
            r_ch_rst <= r_ch_rst & ~(W_ONE << r_idx);
            if (r_idx == IDX_W'(N_CH - 1)) begin
              r_done  <= 1'b1;
              r_state <= ST_RUN;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state  <= ST_WAIT;
          r_cnt    <= '0;
          r_idx    <= '0;
          r_ch_rst <= '0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign ch_rst = r_ch_rst;
  assign done   = r_done;

`ifdef SIM_SRC_SEQ_TICK_EN
  logic w_run;
  logic w_tick;

  assign w_run = (r_state == ST_RUN);

  // Divider only advances in RUN; leaving RUN is only possible through
  // restart/reset, which also clear it, so each RUN entry starts at phase 0.
  sim_src_tick_div #(
    .CNT_W    (CNT_W),
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (w_run),
    .i_clr   (restart),
    .o_pulse (w_tick)
  );

  assign tick = w_tick;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: tb/tb_sim_src_seq.sv
// -----------------------------------------------------------------------------
// tb_sim_src_seq
// Self-checking bench for sim_src_seq. Two instances share rst_n/restart:
//   dut_a : default parameters
//   dut_b : N_CH=1, STAGGER=0, START=1, DURATION=1, TICK_DIV=2
// A reference model tracks k = edges since the last edge that sampled rst_n
// low or restart high, and derives every output from k directly.
// -----------------------------------------------------------------------------
module tb_sim_src_seq;

`ifdef SIM_SRC_SEQ_TICK_EN
  localparam bit TICK_ON = 1'b1;
`else
  localparam bit TICK_ON = 1'b0;
`endif

  localparam int A_N = 4, A_S = 2, A_D = 4, A_G = 1, A_T = 4;
  localparam int B_N = 1, B_S = 1, B_D = 1, B_G = 0, B_T = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       restart;
  logic [3:0] ch_rst_a;
  logic       done_a, tick_a;
  logic [0:0] ch_rst_b;
  logic       done_b, tick_b;

  int tests = 0;
  int fails = 0;
  int k = -1;

  always #5 clk = ~clk;

  sim_src_seq dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .ch_rst  (ch_rst_a),
    .done    (done_a),
    .tick    (tick_a)
  );

  sim_src_seq #(
    .N_CH     (B_N),
    .CNT_W    (8),
    .START    (B_S),
    .DURATION (B_D),
    .STAGGER  (B_G),
    .TICK_DIV (B_T)
  ) dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (restart),
    .ch_rst  (ch_rst_b),
    .done    (done_b),
    .tick    (tick_b)
  );

  function automatic logic [15:0] exp_ch(int kk, int n, int s, int d, int g);
    logic [15:0] v;
    v = 16'h0000;
    for (int i = 0; i < n; i++) v[i] = (kk >= s) && (kk < s + d + i * g);
    return v;
  endfunction

  function automatic logic exp_done(int kk, int n, int s, int d, int g);
    return kk >= s + d + (n - 1) * g;
  endfunction

  function automatic logic exp_tick(int kk, int n, int s, int d, int g, int t);
    int l;
    l = s + d + (n - 1) * g;
    return TICK_ON && (kk > l) && (((kk - l) % t) == 0);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: k=%0d got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Reference sequence position.
  always @(posedge clk) begin
    if (!rst_n || restart) k <= 0;
    else if (k >= 0 && k < 1000000) k <= k + 1;
  end

  // Compare process: model every cycle plus literal pins at known positions.
  always @(negedge clk) begin
    if (k >= 0) begin
      check("a_ch_rst", 16'(ch_rst_a), exp_ch(k, A_N, A_S, A_D, A_G));
      check("a_done",   16'(done_a),   16'(exp_done(k, A_N, A_S, A_D, A_G)));
      check("a_tick",   16'(tick_a),   16'(exp_tick(k, A_N, A_S, A_D, A_G, A_T)));
      check("b_ch_rst", 16'(ch_rst_b), exp_ch(k, B_N, B_S, B_D, B_G));
      check("b_done",   16'(done_b),   16'(exp_done(k, B_N, B_S, B_D, B_G)));
      check("b_tick",   16'(tick_b),   16'(exp_tick(k, B_N, B_S, B_D, B_G, B_T)));
      case (k)
        0: begin
          check("pin_a_k0", {11'd0, ch_rst_a, done_a}, 16'h0000);
          check("pin_b_k0", {14'd0, ch_rst_b, done_b}, 16'h0000);
        end
        1: check("pin_b_k1", {14'd0, ch_rst_b, done_b}, 16'h0002);
        2: begin
          check("pin_a_k2", 16'(ch_rst_a), 16'h000F);
          check("pin_b_k2", {14'd0, ch_rst_b, done_b}, 16'h0001);
        end
        6: check("pin_a_k6", 16'(ch_rst_a), 16'h000E);
        7: check("pin_a_k7", 16'(ch_rst_a), 16'h000C);
        8: check("pin_a_k8", {11'd0, ch_rst_a, done_a}, 16'h0010);
        9: check("pin_a_k9", {11'd0, ch_rst_a, done_a}, 16'h0001);
        13, 17, 21: check("pin_a_tick_on", 16'(tick_a), 16'(TICK_ON));
        14, 16: check("pin_a_tick_off", 16'(tick_a), 16'h0000);
        default: ;
      endcase
    end
  end

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    restart = 1'b0;
    // Reset held low 3 cycles, then a full sequence.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    // Restart sampled at edge 7 (during RELEASE), then full repeat.
    pulse_restart();
    repeat (6) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    repeat (30) @(negedge clk);

    // rst_n low at edge 4 (during HOLD).
    pulse_restart();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);

    // restart held high, then a long RUN stretch past done.
    restart = 1'b1;
    repeat (5) @(negedge clk);
    restart = 1'b0;
    repeat (120) @(negedge clk);

    // rst_n and restart together.
    rst_n   = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    rst_n   = 1'b1;
    restart = 1'b0;
    repeat (25) @(negedge clk);

    // Randomised restarts and resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      restart = ($urandom_range(0, 39) == 0);
      rst_n   = ($urandom_range(0, 59) != 0);
    end
    @(negedge clk);
    restart = 1'b0;
    rst_n   = 1'b1;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
